// File: rtl/acorn128_decrypt.sv
// Bit-serial ACORN-128 decryption core: one state-update step per active cycle,
// streaming AD/ciphertext in, plaintext out, and a tag verdict at the end.
module acorn128_decrypt #(
  parameter int TAG_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [127:0]        key,
  input  logic [127:0]        iv,
  input  logic                ad_none,
  input  logic                ct_none,
  input  logic [TAG_BITS-1:0] tag_in,
  input  logic                ad_valid,
  input  logic                ad_bit,
  input  logic                ad_last,
  output logic                ad_ready,
  input  logic                ct_valid,
  input  logic                ct_bit,
  input  logic                ct_last,
  output logic                ct_ready,
  output logic                pt_valid,
  output logic                pt_bit,
  output logic                pt_last,
  output logic                busy,
  output logic                done,
  output logic                tag_ok
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] LOAD_KEY = 4'd1;
  localparam logic [3:0] LOAD_IV  = 4'd2;
  localparam logic [3:0] INIT     = 4'd3;
  localparam logic [3:0] AD       = 4'd4;
  localparam logic [3:0] AD_PAD   = 4'd5;
  localparam logic [3:0] CT       = 4'd6;
  localparam logic [3:0] CT_PAD   = 4'd7;
  localparam logic [3:0] FINAL    = 4'd8;
  localparam logic [3:0] DONE     = 4'd9;

  localparam logic [10:0] TAG_OFF = 11'(768 - TAG_BITS);

  logic [3:0]          fsm, fsm_nxt;
  logic [10:0]         cnt;
  logic [292:0]        st, t, st_nxt;
  logic [127:0]        key_r, iv_r;
  logic [TAG_BITS-1:0] tag_r;
  logic                ad_none_r, ct_none_r, mism;
  logic                ks, f, m, ca, cb, step, phase_end, tag_win, ks_bad;

  function automatic logic maj(input logic a, input logic b, input logic c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // Six in-place feedback XORs; each right-hand side reads bits not yet updated.
  always_comb begin
    t      = st;
    t[289] = st[289] ^ st[235] ^ st[230];
    t[230] = st[230] ^ st[196] ^ st[193];
    t[193] = st[193] ^ st[160] ^ st[154];
    t[154] = st[154] ^ st[111] ^ st[107];
    t[107] = st[107] ^ st[66]  ^ st[61];
    t[61]  = st[61]  ^ st[23]  ^ st[0];
    ks     = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ ch(t[230], t[111], t[66]);
  end

  always_comb begin
    step = 1'b0;
    m    = 1'b0;
    ca   = 1'b1;
    cb   = 1'b1;
    case (fsm)
      LOAD_KEY: begin step = 1'b1; m = key_r[cnt[6:0]]; end
      LOAD_IV:  begin step = 1'b1; m = iv_r[cnt[6:0]]; end
      INIT:     begin step = 1'b1; m = key_r[cnt[6:0]] ^ (cnt == 11'd0); end
      AD:       begin step = ad_valid; m = ad_bit; end
      AD_PAD:   begin step = 1'b1; m = (cnt == 11'd0); ca = ~cnt[7]; end
      CT:       begin step = ct_valid; m = ct_bit ^ ks; cb = 1'b0; end
      CT_PAD:   begin step = 1'b1; m = (cnt == 11'd0); ca = ~cnt[7]; cb = 1'b0; end
      FINAL:    begin step = 1'b1; end
      default:  ;
    endcase
  end

  always_comb begin
    f      = t[0] ^ ~t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
    st_nxt = {f ^ m, t[292:1]};
  end

  always_comb begin
    phase_end = 1'b0;
    fsm_nxt   = fsm;
    case (fsm)
      LOAD_KEY: begin phase_end = (cnt == 11'd127);  fsm_nxt = LOAD_IV; end
      LOAD_IV:  begin phase_end = (cnt == 11'd127);  fsm_nxt = INIT; end
      INIT:     begin phase_end = (cnt == 11'd1535); fsm_nxt = ad_none_r ? AD_PAD : AD; end
      AD:       begin phase_end = ad_last;           fsm_nxt = AD_PAD; end
      AD_PAD:   begin phase_end = (cnt == 11'd255);  fsm_nxt = ct_none_r ? CT_PAD : CT; end
      CT:       begin phase_end = ct_last;           fsm_nxt = CT_PAD; end
      CT_PAD:   begin phase_end = (cnt == 11'd255);  fsm_nxt = FINAL; end
      FINAL:    begin phase_end = (cnt == 11'd767);  fsm_nxt = DONE; end
      default:  ;
    endcase
  end

  // Tag bits are consumed LSB-first by shifting, matching keystream order.
  assign tag_win = (fsm == FINAL) && (cnt >= TAG_OFF);
  assign ks_bad  = tag_win && (ks != tag_r[0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm       <= IDLE;
      cnt       <= '0;
      st        <= '0;
      key_r     <= '0;
      iv_r      <= '0;
      tag_r     <= '0;
      ad_none_r <= 1'b0;
      ct_none_r <= 1'b0;
      mism      <= 1'b0;
      pt_valid  <= 1'b0;
      pt_bit    <= 1'b0;
      pt_last   <= 1'b0;
      tag_ok    <= 1'b0;
    end else begin
      pt_valid <= 1'b0;
      pt_last  <= 1'b0;
      if ((fsm == IDLE || fsm == DONE) && start) begin
        key_r     <= key;
        iv_r      <= iv;
        tag_r     <= tag_in;
        ad_none_r <= ad_none;
        ct_none_r <= ct_none;
        st        <= '0;
        cnt       <= '0;
        mism      <= 1'b0;
        tag_ok    <= 1'b0;
        fsm       <= LOAD_KEY;
      end else if (fsm == DONE) begin
        fsm <= IDLE;
      end else if (step) begin
        st  <= st_nxt;
        cnt <= phase_end ? 11'd0 : cnt + 11'd1;
        if (phase_end) fsm <= fsm_nxt;
        if (fsm == CT) begin
          pt_valid <= 1'b1;
          pt_bit   <= m;
          pt_last  <= ct_last;
        end
        if (tag_win) begin
          tag_r <= tag_r >> 1;
          if (ks_bad) mism <= 1'b1;
        end
        if (fsm == FINAL && phase_end) tag_ok <= ~(mism | ks_bad);
      end
    end
  end

  assign ad_ready = (fsm == AD);
  assign ct_ready = (fsm == CT);
  assign done     = (fsm == DONE);
  assign busy     = (fsm != IDLE) && (fsm != DONE);

endmodule

// File: tb/tb_acorn128_decrypt.sv
// Self-checking bench for acorn128_decrypt against a sequential ACORN-128 model.
module tb_acorn128_decrypt;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0, iv = '0;
  logic         ad_none = 1'b0, ct_none = 1'b0;
  logic [127:0] tag_in = '0;
  logic         ad_valid = 1'b0, ad_bit = 1'b0, ad_last = 1'b0, ad_ready;
  logic         ct_valid = 1'b0, ct_bit = 1'b0, ct_last = 1'b0, ct_ready;
  logic         pt_valid, pt_bit, pt_last, busy, done, tag_ok;

  int tests = 0;
  int fails = 0;

  acorn128_decrypt #(.TAG_BITS(128)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .iv(iv),
    .ad_none(ad_none), .ct_none(ct_none), .tag_in(tag_in),
    .ad_valid(ad_valid), .ad_bit(ad_bit), .ad_last(ad_last), .ad_ready(ad_ready),
    .ct_valid(ct_valid), .ct_bit(ct_bit), .ct_last(ct_last), .ct_ready(ct_ready),
    .pt_valid(pt_valid), .pt_bit(pt_bit), .pt_last(pt_last),
    .busy(busy), .done(done), .tag_ok(tag_ok)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] V1  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [63:0]  PT1 = 64'h0123456789ABCDEF;
  localparam logic [23:0]  AD1 = 24'hA5A5A5;

  // ---------------- reference model ----------------
  logic [292:0] ms;
  bit ad_q[$], in_q[$], out_q[$], ct_q[$], pt_q[$], ptl_q[$];
  logic [127:0] tag_gold, tag_empty;

  function automatic bit mj(input bit a, input bit b, input bit c);
    return (int'(a) + int'(b) + int'(c)) >= 2;
  endfunction

  function automatic bit cho(input bit x, input bit y, input bit z);
    return x ? y : z;
  endfunction

  // With dec_ct the message bit is recovered as input^ks before it is absorbed.
  task automatic mstep(input bit min, input bit ca, input bit cb, input bit dec_ct,
                       output bit ks, output bit m);
    bit f;
    ms[289] ^= ms[235] ^ ms[230];
    ms[230] ^= ms[196] ^ ms[193];
    ms[193] ^= ms[160] ^ ms[154];
    ms[154] ^= ms[111] ^ ms[107];
    ms[107] ^= ms[66]  ^ ms[61];
    ms[61]  ^= ms[23]  ^ ms[0];
    ks = ms[12] ^ ms[154] ^ mj(ms[235], ms[61], ms[193]) ^ cho(ms[230], ms[111], ms[66]);
    f  = ms[0] ^ !ms[107] ^ mj(ms[244], ms[23], ms[160]) ^ (ca & ms[196]) ^ (cb & ks);
    m  = dec_ct ? (min ^ ks) : min;
    ms = {f ^ m, ms[292:1]};
  endtask

  task automatic model_run(input logic [127:0] k, input logic [127:0] v, input bit dec,
                           input bit adn, input bit ctn, output logic [127:0] tag);
    bit ks, m;
    ms = '0;
    out_q.delete();
    tag = '0;
    for (int i = 0; i < 128; i++) mstep(k[i], 1, 1, 0, ks, m);
    for (int i = 0; i < 128; i++) mstep(v[i], 1, 1, 0, ks, m);
    for (int i = 0; i < 1536; i++) mstep(k[i % 128] ^ (i == 0), 1, 1, 0, ks, m);
    if (!adn) foreach (ad_q[i]) mstep(ad_q[i], 1, 1, 0, ks, m);
    for (int i = 0; i < 256; i++) mstep(i == 0, i < 128, 1, 0, ks, m);
    if (!ctn) foreach (in_q[i]) begin
      mstep(in_q[i], 1, 0, dec, ks, m);
      out_q.push_back(dec ? m : (m ^ ks));
    end
    for (int i = 0; i < 256; i++) mstep(i == 0, i < 128, 0, 0, ks, m);
    for (int i = 0; i < 768; i++) begin
      mstep(0, 1, 1, 0, ks, m);
      if (i >= 640) tag[i - 640] = ks;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_op(input logic [127:0] k, input logic [127:0] v, input logic [127:0] tg,
                        input bit adn, input bit ctn, input bit stall, input bit glitch,
                        output int cycles, output int stalls, output bit tok,
                        output bit rdy_seen, output bit timeout);
    int ai, ci;
    bit adr, ctr;
    pt_q.delete();
    ptl_q.delete();
    ai = 0; ci = 0; stalls = 0; rdy_seen = 0; tok = 0; timeout = 1;
    key = k; iv = v; tag_in = tg; ad_none = adn; ct_none = ctn;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 1;
    while (cycles < 10000) begin
      adr = ad_ready;
      ctr = ct_ready;
      if (adr || ctr) rdy_seen = 1;
      if (adr && ai < ad_q.size()) begin
        ad_valid = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
        ad_bit   = ad_q[ai];
        ad_last  = (ai == ad_q.size() - 1);
        if (!ad_valid) stalls++;
      end else begin
        ad_valid = 1'($urandom); ad_bit = 1'($urandom); ad_last = 1'($urandom);
      end
      if (ctr && ci < ct_q.size()) begin
        ct_valid = stall ? ($urandom_range(0, 99) >= 30) : 1'b1;
        ct_bit   = ct_q[ci];
        ct_last  = (ci == ct_q.size() - 1);
        if (!ct_valid) stalls++;
      end else begin
        ct_valid = 1'($urandom); ct_bit = 1'($urandom); ct_last = 1'($urandom);
      end
      if (glitch && cycles == 600) begin
        start = 1'b1; key = ~k; iv = ~v; tag_in = ~tg; ad_none = ~adn; ct_none = ~ctn;
      end
      @(posedge clk); #1;
      cycles++;
      start = 1'b0;
      if (adr && ad_valid) ai++;
      if (ctr && ct_valid) ci++;
      if (pt_valid) begin
        pt_q.push_back(pt_bit);
        ptl_q.push_back(pt_last);
      end
      if (done) begin
        tok = tag_ok;
        timeout = 0;
        break;
      end
    end
    ad_valid = 1'b0; ct_valid = 1'b0;
  endtask

  function automatic logic [63:0] pack64(input bit q[$]);
    logic [63:0] w = '0;
    foreach (q[i]) if (i < 64) w[i] = q[i];
    return w;
  endfunction

  task automatic load_vector();
    ad_q.delete(); in_q.delete(); ct_q.delete();
    for (int i = 0; i < 24; i++) ad_q.push_back(AD1[i]);
    for (int i = 0; i < 64; i++) in_q.push_back(PT1[i]);
    model_run(K1, V1, 0, 0, 0, tag_gold);
    foreach (out_q[i]) ct_q.push_back(out_q[i]);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (tag_ok !== 1'b0)   begin fails++; $display("FAIL reset_tag_ok got %b want 0", tag_ok); end
    tests++; if (pt_valid !== 1'b0) begin fails++; $display("FAIL reset_pt_valid got %b want 0", pt_valid); end
    tests++; if (ad_ready !== 1'b0) begin fails++; $display("FAIL reset_ad_ready got %b want 0", ad_ready); end
    tests++; if (ct_ready !== 1'b0) begin fails++; $display("FAIL reset_ct_ready got %b want 0", ct_ready); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_empty();
    int cyc, st; bit tok, rdy, to;
    ad_q.delete(); in_q.delete(); ct_q.delete();
    model_run('0, '0, 0, 1, 1, tag_empty);
    // A stray start mid-run with inverted inputs must change nothing.
    run_op('0, '0, tag_empty, 1, 1, 0, 1, cyc, st, tok, rdy, to);
    tests++; if (to)          begin fails++; $display("FAIL empty_timeout no done within budget"); end
    tests++; if (cyc != 3073) begin fails++; $display("FAIL empty_cycles got %0d want 3073", cyc); end
    tests++; if (tok !== 1'b1) begin fails++; $display("FAIL empty_tag_ok got %b want 1", tok); end
    tests++; if (pt_q.size() != 0) begin fails++; $display("FAIL empty_pt_valid got %0d pt bits want 0", pt_q.size()); end
    tests++; if (rdy)         begin fails++; $display("FAIL empty_ready got ready high want never"); end
  endtask

  task automatic test_vector();
    int cyc, st; bit tok, rdy, to;
    load_vector();
    run_op(K1, V1, tag_gold, 0, 0, 0, 0, cyc, st, tok, rdy, to);
    tests++; if (to)           begin fails++; $display("FAIL vec_timeout no done within budget"); end
    tests++; if (cyc != 3161)  begin fails++; $display("FAIL vec_cycles got %0d want 3161", cyc); end
    tests++; if (tok !== 1'b1) begin fails++; $display("FAIL vec_tag_ok got %b want 1", tok); end
    tests++; if (pt_q.size() != 64) begin fails++; $display("FAIL vec_pt_count got %0d want 64", pt_q.size()); end
    tests++; if (pack64(pt_q) !== PT1) begin fails++; $display("FAIL vec_pt got %h want %h", pack64(pt_q), PT1); end
    tests++; if (pack64(ptl_q) !== 64'h8000000000000000)
      begin fails++; $display("FAIL vec_pt_last got %h want 8000000000000000", pack64(ptl_q)); end
  endtask

  task automatic test_stalls();
    int cyc, st; bit tok, rdy, to;
    load_vector();
    run_op(K1, V1, tag_gold, 0, 0, 1, 0, cyc, st, tok, rdy, to);
    tests++; if (to)           begin fails++; $display("FAIL stall_timeout no done within budget"); end
    tests++; if (cyc != 3161 + st) begin fails++; $display("FAIL stall_cycles got %0d want %0d", cyc, 3161 + st); end
    tests++; if (tok !== 1'b1) begin fails++; $display("FAIL stall_tag_ok got %b want 1", tok); end
    tests++; if (pack64(pt_q) !== PT1 || pt_q.size() != 64)
      begin fails++; $display("FAIL stall_pt got %h (%0d bits) want %h", pack64(pt_q), pt_q.size(), PT1); end
  endtask

  task automatic test_bad_tag();
    int cyc, st; bit tok, rdy, to;
    load_vector();
    run_op(K1, V1, tag_gold ^ (128'd1 << 5), 0, 0, 0, 0, cyc, st, tok, rdy, to);
    tests++; if (to || tok !== 1'b0) begin fails++; $display("FAIL badtag_tag_ok got %b (timeout %b) want 0", tok, to); end
    tests++; if (pack64(pt_q) !== PT1) begin fails++; $display("FAIL badtag_pt got %h want %h", pack64(pt_q), PT1); end
  endtask

  task automatic test_bad_ct();
    int cyc, st; bit tok, rdy, to;
    logic [127:0] tdummy;
    logic [63:0] exp_pt;
    load_vector();
    ct_q[17] = !ct_q[17];
    in_q.delete();
    foreach (ct_q[i]) in_q.push_back(ct_q[i]);
    model_run(K1, V1, 1, 0, 0, tdummy);
    exp_pt = pack64(out_q);
    run_op(K1, V1, tag_gold, 0, 0, 0, 0, cyc, st, tok, rdy, to);
    tests++; if (to || tok !== 1'b0) begin fails++; $display("FAIL badct_tag_ok got %b (timeout %b) want 0", tok, to); end
    tests++; if (pt_q.size() != 64 || pt_q[17] !== !PT1[17])
      begin fails++; $display("FAIL badct_bit17 got %h want bit17 inverted from %h", pack64(pt_q), PT1); end
    tests++; if (pack64(pt_q) !== exp_pt) begin fails++; $display("FAIL badct_pt got %h want %h", pack64(pt_q), exp_pt); end
  endtask

  task automatic test_reset_mid();
    int cyc, st; bit tok, rdy, to;
    load_vector();
    run_op(K1, V1, tag_gold, 0, 0, 0, 0, cyc, st, tok, rdy, to);
    key = K1; iv = V1; tag_in = tag_gold; ad_none = 0; ct_none = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (400) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    tests++; if ({busy, done, tag_ok, pt_valid, ad_ready, ct_ready} !== 6'b0)
      begin fails++; $display("FAIL midreset_outputs got %b want 000000", {busy, done, tag_ok, pt_valid, ad_ready, ct_ready}); end
    repeat (2) @(negedge clk);
    tests++; if ({busy, done, tag_ok, pt_valid} !== 4'b0)
      begin fails++; $display("FAIL midreset_hold got %b want 0000", {busy, done, tag_ok, pt_valid}); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    run_op(K1, V1, tag_gold, 0, 0, 0, 0, cyc, st, tok, rdy, to);
    tests++; if (to || cyc != 3161) begin fails++; $display("FAIL rerun_cycles got %0d want 3161", cyc); end
    tests++; if (tok !== 1'b1) begin fails++; $display("FAIL rerun_tag_ok got %b want 1", tok); end
    tests++; if (pack64(pt_q) !== PT1) begin fails++; $display("FAIL rerun_pt got %h want %h", pack64(pt_q), PT1); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_vector();
    test_stalls();
    test_bad_tag();
    test_bad_ct();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/acorn128_decrypt.md
Name: acorn128_decrypt

Overview:
Bit-serial ACORN-128 authenticated decryption core; it is the receive-side counterpart of the encryption/keystream path.
- Owns the full 293-bit state and performs one state-update step per active clock.
- Phases: key/IV load, initialisation, associated-data (AD) absorption, ciphertext decryption, finalisation and tag compare.
- Consumes AD and ciphertext as valid/ready bit streams; emits plaintext bits and a tag verdict.

Parameters:
- TAG_BITS, 128, tag length compared; always the last TAG_BITS keystream bits of finalisation (1..128).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins an operation; ignored while busy=1
- key  in  128  K[i]=key[i]; sampled at start
- iv  in  128  V[i]=iv[i]; sampled at start
- ad_none  in  1  sampled at start; 1 means the AD phase is skipped
- ct_none  in  1  sampled at start; 1 means the CT phase is skipped
- tag_in  in  TAG_BITS  expected tag; sampled at start
- ad_valid / ad_bit / ad_last  in  1 each  AD stream; ad_last marks the final bit
- ad_ready  out  1  high only in state AD
- ct_valid / ct_bit / ct_last  in  1 each  ciphertext stream; ct_last marks the final bit
- ct_ready  out  1  high only in state CT
- pt_valid / pt_bit / pt_last  out  1 each  registered plaintext stream
- busy  out  1  high from start-accept until done
- done  out  1  one-cycle pulse at end of operation
- tag_ok  out  1  held until next start or reset

Behaviour:
State-update step (one per active cycle), with message bit m and control bits ca and cb:
- Six in-place XOR updates, in order:
  - S289^=S235^S230
  - S230^=S196^S193
  - S193^=S160^S154
  - S154^=S111^S107
  - S107^=S66^S61
  - S61^=S23^S0
- Using the updated bits:
  - ks = S12^S154^maj(S235,S61,S193)^ch(S230,S111,S66)
  - f = S0^~S107^maj(S244,S23,S160)^(ca&S196)^(cb&ks)
- Shift down one position; S292 = f^m.

Reset: state=0, FSM=IDLE, counter=0, all outputs 0.

FSM (counter is 11 bits, counts steps within a phase):
- IDLE: on start, latch key/iv/tag_in/ad_none/ct_none, zero the state, enter LOAD_KEY; busy=1.
- LOAD_KEY: 128 steps, m=K[i], ca=cb=1.
- LOAD_IV: 128 steps, m=V[i], ca=cb=1.
- INIT: 1536 steps, m=K[i mod 128], except the first step uses m=K[0]^1; ca=cb=1.
  - Then go to AD, or to AD_PAD if ad_none.
- AD: a step occurs only on ad_valid&ad_ready, with m=ad_bit, ca=cb=1. No step when ad_valid=0 (stall). After the ad_last bit, go to AD_PAD.
- AD_PAD: 256 steps, m=1 on the first step and 0 after; ca=1 for steps 0-127 and 0 for steps 128-255; cb=1.
  - Then go to CT, or to CT_PAD if ct_none.
- CT: a step occurs only on ct_valid&ct_ready.
  - p = ct_bit^ks, with ks taken from the same step; m=p; ca=1, cb=0.
  - Next cycle: pt_valid=1, pt_bit=p, pt_last=ct_last.
  - After the ct_last bit, go to CT_PAD.
- CT_PAD: 256 steps, same m/ca schedule as AD_PAD; cb=0.
- FINAL: 768 steps, m=0, ca=cb=1.
  - Keystream of step 768-TAG_BITS+j is compared with tag_in[j].
  - A sticky mismatch flag accumulates the comparison.
- DONE: one cycle: done=1, tag_ok=~mismatch, busy=0, then IDLE.

Boundary conditions:
- Cycle count, no stalls: start-accept to done = 3072+N_ad+N_ct+1 cycles.
- Stall cycles add one cycle each and leave the state and counter untouched.
- pt_valid is 0 in every cycle with no accepted ct bit.
- ad_last/ct_last are honoured only with their valid; asserting last on the first bit gives N=1.
- ad_none/ct_none=1: the corresponding ready never asserts, and stream inputs are ignored.
- start while busy: ignored, no side effect.
- Reset mid-operation: immediate return to reset values; tag_ok=0.
- tag_ok is cleared at start-accept. The plaintext is released before verification; consumers gate it on tag_ok.

Test Plan:
- key=0, iv=0, ad_none=ct_none=1, tag_in=golden-model tag -> done exactly 3073 cycles after start, tag_ok=1, pt_valid never high, ad_ready/ct_ready never high.
- Golden model encrypts 64-bit PT 0x0123456789ABCDEF with key=0x000102..0F, iv=0x0F0E..00, 24-bit AD 0xA5A5A5; bench streams AD and CT with no stalls -> pt bits equal the PT bits in order, pt_last on bit 63, tag_ok=1, done at cycle 3073+88.
- Same vector with random valid gaps (about 30% low) -> identical pt sequence and tag_ok=1; done delayed by exactly the number of stall cycles.
- Same vector with tag_in bit 5 flipped -> tag_ok=0; pt identical to the unflipped run.
- Same vector with ct bit 17 flipped -> pt bit 17 inverted, later pt bits differ from the golden PT, tag_ok=0.
- Reset pulsed during INIT, then new start with the first vector -> all outputs 0 during reset; the second run reproduces the first-vector results exactly.
